// File: rtl/i2c_bus_monitor.sv
// I2C bus-state monitor: filtered START/STOP detection, bus-busy tracking,
// SMBus-style idle timeout and SCL-stuck-low flag. Inputs must already be synchronised.
module i2c_bus_monitor #(
  parameter int FILT_LEN  = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 SDA_sync,
  input  logic                 SCL_sync,
  input  logic [TIMEOUT_W-1:0] idle_timeout,
  input  logic [TIMEOUT_W-1:0] low_timeout,
  input  logic                 clr_stuck,
  output logic                 bus_busy,
  output logic                 start_det,
  output logic                 rstart_det,
  output logic                 stop_det,
  output logic                 idle_to,
  output logic                 scl_stuck
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILT_LEN);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic                 prev_scl_q, prev_sda_q;
  logic [FW-1:0]        start_cnt_q, start_cnt_d;
  logic [FW-1:0]        stop_cnt_q, stop_cnt_d;
  logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [TIMEOUT_W-1:0] low_cnt_q, low_cnt_d;
  logic                 start_qual, stop_qual, start_conf, stop_conf;
  logic                 idle_hit, low_hit;

  always_comb begin
    start_qual = SCL_sync & ~SDA_sync;
    stop_qual  = SCL_sync & SDA_sync;

    // A run may only begin right after its precondition sample; once begun it
    // keeps counting until a non-qualifying sample breaks it.
    start_cnt_d = '0;
    if (start_qual && (start_cnt_q != '0 || (prev_scl_q && prev_sda_q)))
      start_cnt_d = (start_cnt_q == FMAX) ? FMAX : start_cnt_q + FW'(1);

    stop_cnt_d = '0;
    if (stop_qual && (stop_cnt_q != '0 || (prev_scl_q && !prev_sda_q)))
      stop_cnt_d = (stop_cnt_q == FMAX) ? FMAX : stop_cnt_q + FW'(1);

    // Saturation makes confirmation fire only on the FILT_LEN-th sample.
    start_conf = (start_cnt_d == FMAX) && (start_cnt_q != FMAX);
    stop_conf  = (stop_cnt_d == FMAX) && (stop_cnt_q != FMAX);

    idle_cnt_d = '0;
    if (state_q == BUSY && stop_qual)
      idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + TIMEOUT_W'(1);

    low_cnt_d = '0;
    if (!SCL_sync)
      low_cnt_d = (&low_cnt_q) ? low_cnt_q : low_cnt_q + TIMEOUT_W'(1);

    // Thresholds are compared against counts that include the current sample.
    idle_hit = (idle_timeout != '0) && (idle_cnt_d >= idle_timeout);
    low_hit  = (low_timeout != '0) && (low_cnt_d >= low_timeout);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      prev_scl_q  <= 1'b1;
      prev_sda_q  <= 1'b1;
      start_cnt_q <= '0;
      stop_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      low_cnt_q   <= '0;
      bus_busy    <= 1'b0;
      start_det   <= 1'b0;
      rstart_det  <= 1'b0;
      stop_det    <= 1'b0;
      idle_to     <= 1'b0;
      scl_stuck   <= 1'b0;
    end else begin
      prev_scl_q  <= SCL_sync;
      prev_sda_q  <= SDA_sync;
      start_cnt_q <= start_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      low_cnt_q   <= low_cnt_d;
      scl_stuck   <= low_hit | (scl_stuck & ~clr_stuck);
      start_det   <= 1'b0;
      rstart_det  <= 1'b0;
      stop_det    <= 1'b0;
      idle_to     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stop_conf) begin
            stop_det <= 1'b1;
          end else if (start_conf) begin
            state_q   <= BUSY;
            bus_busy  <= 1'b1;
            start_det <= 1'b1;
          end
        end
        BUSY: begin
          // STOP outranks a timeout reached on the same edge.
          if (stop_conf) begin
            state_q    <= IDLE;
            bus_busy   <= 1'b0;
            stop_det   <= 1'b1;
            idle_cnt_q <= '0;
          end else if (start_conf) begin
            rstart_det <= 1'b1;
          end else if (idle_hit) begin
            state_q    <= IDLE;
            bus_busy   <= 1'b0;
            idle_to    <= 1'b1;
            idle_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: two instances (FILT_LEN=2 and FILT_LEN=1) share one
// stimulus; a sample-history model is compared every cycle, plus literal spot checks.
module tb_i2c_bus_monitor;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        scl_s, sda_s, clr_s;
  logic [15:0] idle_th, low_th;

  logic b0, sd0, rs0, sp0, it0, st0;
  logic b1, sd1, rs1, sp1, it1, st1;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  i2c_bus_monitor #(.FILT_LEN(2), .TIMEOUT_W(16)) dut0 (
    .clk(clk), .n_rst(n_rst), .SDA_sync(sda_s), .SCL_sync(scl_s),
    .idle_timeout(idle_th), .low_timeout(low_th), .clr_stuck(clr_s),
    .bus_busy(b0), .start_det(sd0), .rstart_det(rs0), .stop_det(sp0),
    .idle_to(it0), .scl_stuck(st0)
  );

  i2c_bus_monitor #(.FILT_LEN(1), .TIMEOUT_W(16)) dut1 (
    .clk(clk), .n_rst(n_rst), .SDA_sync(sda_s), .SCL_sync(scl_s),
    .idle_timeout(idle_th), .low_timeout(low_th), .clr_stuck(clr_s),
    .bus_busy(b1), .start_det(sd1), .rstart_det(rs1), .stop_det(sp1),
    .idle_to(it1), .scl_stuck(st1)
  );

  // Model: history of the last samples (index 0 = newest); an event is
  // confirmed when the newest F samples qualify and the one before them is its precondition.
  logic hist_scl [0:3];
  logic hist_sda [0:3];
  int   m_low;
  bit   m_stuck;
  bit   m_busy [0:1];
  bit   m_sd [0:1], m_rs [0:1], m_sp [0:1], m_it [0:1];
  int   m_idle [0:1];

  function automatic bit window_hit(int f, bit is_stop);
    bit ok = 1'b1;
    for (int i = 0; i < f; i++)
      if (!(hist_scl[i] == 1'b1 && hist_sda[i] == is_stop)) ok = 1'b0;
    if (!(hist_scl[f] == 1'b1 && hist_sda[f] == !is_stop)) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_scl[i] = 1'b1;
        hist_sda[i] = 1'b1;
      end
      m_low = 0;
      m_stuck = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0; m_idle[k] = 0;
        m_sd[k] = 1'b0; m_rs[k] = 1'b0; m_sp[k] = 1'b0; m_it[k] = 1'b0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        hist_scl[i] = hist_scl[i-1];
        hist_sda[i] = hist_sda[i-1];
      end
      hist_scl[0] = scl_s;
      hist_sda[0] = sda_s;
      m_low = scl_s ? 0 : ((m_low < 65535) ? m_low + 1 : m_low);
      if (low_th != 0 && m_low >= int'(low_th)) m_stuck = 1'b1;
      else if (clr_s) m_stuck = 1'b0;
      for (int k = 0; k < 2; k++) begin
        int  f;
        bit  stc, spc;
        f = (k == 0) ? 2 : 1;
        stc = window_hit(f, 1'b0);
        spc = window_hit(f, 1'b1);
        if (m_busy[k] && scl_s && sda_s) m_idle[k] = (m_idle[k] < 65535) ? m_idle[k] + 1 : m_idle[k];
        else m_idle[k] = 0;
        m_sd[k] = 1'b0; m_rs[k] = 1'b0; m_sp[k] = 1'b0; m_it[k] = 1'b0;
        if (spc) begin
          m_sp[k] = 1'b1;
          m_busy[k] = 1'b0;
        end else if (stc) begin
          if (m_busy[k]) m_rs[k] = 1'b1;
          else m_sd[k] = 1'b1;
          m_busy[k] = 1'b1;
        end else if (m_busy[k] && idle_th != 0 && m_idle[k] >= int'(idle_th)) begin
          m_it[k] = 1'b1;
          m_busy[k] = 1'b0;
        end
        if (!m_busy[k]) m_idle[k] = 0;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_busy0", b0, m_busy[0]);   chk("model_start0", sd0, m_sd[0]);
      chk("model_rstart0", rs0, m_rs[0]);  chk("model_stop0", sp0, m_sp[0]);
      chk("model_idleto0", it0, m_it[0]);  chk("model_stuck0", st0, m_stuck);
      chk("model_busy1", b1, m_busy[1]);   chk("model_start1", sd1, m_sd[1]);
      chk("model_rstart1", rs1, m_rs[1]);  chk("model_stop1", sp1, m_sp[1]);
      chk("model_idleto1", it1, m_it[1]);  chk("model_stuck1", st1, m_stuck);
    end
  end

  task automatic step(input logic scl, input logic sda);
    scl_s = scl;
    sda_s = sda;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; scl_s = 1'b1; sda_s = 1'b1; clr_s = 1'b0;
    idle_th = '0; low_th = '0;
    step(1, 1);
    check_en = 1'b1;
    step(1, 1);
    chk("reset_busy", b0, 1'b0); chk("reset_start", sd0, 1'b0); chk("reset_stuck", st0, 1'b0);
    n_rst = 1'b1;

    // START with filtering
    repeat (3) step(1, 1);
    step(1, 0);
    chk("start_lat1_f2", sd0, 1'b0); chk("start_lat1_f1", sd1, 1'b1); chk("busy_f1", b1, 1'b1);
    step(1, 0);
    chk("start_lat2_f2", sd0, 1'b1); chk("busy_f2", b0, 1'b1); chk("start_once_f1", sd1, 1'b0);
    step(1, 0);
    chk("start_pulse_end", sd0, 1'b0); chk("busy_hold", b0, 1'b1);

    // STOP glitch then real STOP
    step(1, 1);
    chk("glitch_nostop", sp0, 1'b0); chk("glitch_f1_stop", sp1, 1'b1);
    step(1, 0);
    chk("glitch_busy", b0, 1'b1); chk("glitch_nostop2", sp0, 1'b0);
    step(1, 1);
    chk("stop_lat1", sp0, 1'b0);
    step(1, 1);
    chk("stop_lat2", sp0, 1'b1); chk("stop_idle", b0, 1'b0);

    // repeated START
    step(1, 1);
    step(1, 0); step(1, 0);
    chk("start2", sd0, 1'b1);
    step(0, 0); step(0, 1); step(1, 1);
    chk("no_stop_at_rise", sp0, 1'b0);
    step(1, 0);
    chk("rstart_lat1", rs0, 1'b0);
    step(1, 0);
    chk("rstart", rs0, 1'b1); chk("rstart_nostart", sd0, 1'b0); chk("rstart_busy", b0, 1'b1);
    step(1, 0);
    chk("rstart_end", rs0, 1'b0);

    // idle timeout
    idle_th = 16'd10;
    step(0, 0); step(0, 1);
    repeat (9) step(1, 1);
    chk("idle9_busy", b0, 1'b1); chk("idle9_to", it0, 1'b0);
    step(1, 1);
    chk("idle10_to", it0, 1'b1); chk("idle10_busy", b0, 1'b0);
    chk("idle10_nostop", sp0, 1'b0); chk("idle10_to_f1", it1, 1'b1);
    step(1, 1);
    chk("idle_to_end", it0, 1'b0);
    idle_th = '0;
    step(1, 0); step(1, 0);
    chk("restart_busy", b0, 1'b1);
    step(0, 0); step(0, 1);
    repeat (30) step(1, 1);
    chk("idle_disabled_busy", b0, 1'b1);

    // SCL stuck low
    low_th = 16'd5;
    repeat (4) step(0, 1);
    chk("stuck4", st0, 1'b0);
    step(0, 1);
    chk("stuck5", st0, 1'b1);
    clr_s = 1'b1; step(0, 1);
    chk("stuck_clr_blocked", st0, 1'b1);
    clr_s = 1'b0; step(1, 1);
    chk("stuck_sticky", st0, 1'b1);
    clr_s = 1'b1; step(1, 1);
    chk("stuck_cleared", st0, 1'b0);
    clr_s = 1'b0;
    repeat (5) step(0, 1);
    chk("stuck_again", st0, 1'b1);
    step(1, 1);
    chk("stuck_keeps_busy", b0, 1'b1);

    // mid-BUSY reset
    n_rst = 1'b0;
    step(1, 1);
    chk("rst_busy", b0, 1'b0); chk("rst_nostop", sp0, 1'b0);
    chk("rst_stuck", st0, 1'b0); chk("rst_busy_f1", b1, 1'b0);
    n_rst = 1'b1;
    step(1, 0);
    chk("post_rst_f1", sd1, 1'b1); chk("post_rst_f2_lat", sd0, 1'b0);
    step(1, 0);
    chk("post_rst_f2", sd0, 1'b1);

    // STOP and timeout on the same edge
    idle_th = 16'd2;
    step(1, 1);
    chk("tie_lat1", sp0, 1'b0); chk("tie_busy1", b0, 1'b1);
    step(1, 1);
    chk("tie_stop", sp0, 1'b1); chk("tie_noto", it0, 1'b0); chk("tie_idle", b0, 1'b0);
    idle_th = '0;

    // live threshold changes
    step(1, 0); step(1, 0);
    low_th = 16'd3;
    step(0, 0); step(0, 0);
    low_th = '0;
    step(0, 0);
    chk("low_disabled", st0, 1'b0);
    low_th = 16'd2;
    step(0, 0);
    chk("low_lowered", st0, 1'b1);
    step(1, 0); step(1, 1); step(1, 1);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
